front_panel_cmd: RTL

FRONT_PANEL_CMD -- requirements
Module: front_panel_cmd

---
 rtl/front_panel_cmd.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/front_panel_cmd.sv
// Front-panel command decoder: debounced toggles become one-shot examine/examine-next/deposit strobes and a run/stop level.
// Optional feature: define FP_AUTOREPEAT_EN to repeat EXAMINE NEXT while the toggle is held.
module front_panel_cmd #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sw_examine,
    input  logic        sw_examine_next,
    input  logic        sw_deposit,
    input  logic        sw_stop,
    input  logic        sw_run,
    input  logic [15:0] sense_sw,
    input  logic        stopped,
    output logic        examine,
    output logic        examine_next,
    output logic        deposit,
    output logic        run_req,
    output logic [7:0]  lo_addr,
    output logic [7:0]  hi_addr,
    output logic [7:0]  dep_data
);

    localparam int NSW     = 5;
    localparam int SW_EXAM = 0;
    localparam int SW_EXN  = 1;
    localparam int SW_DEP  = 2;
    localparam int SW_STOP = 3;
    localparam int SW_RUN  = 4;
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 16777215) begin : g_param_check
        $error("front_panel_cmd: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
    end

    typedef enum logic [1:0] {IDLE, LATCH, PULSE, RELEASE} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_EXAM, CMD_EXN, CMD_DEP} cmd_t;

    logic [NSW-1:0] raw;
    logic [NSW-1:0] db;
    logic [NSW-1:0] db_q;
    logic [NSW-1:0] rise;
    logic [NSW-1:0] accept;
    logic [15:0]    db_cnt [NSW];
    logic [15:0]    sense_s1;
    logic [15:0]    sense_s2;
    state_t         state;
    state_t         state_nxt;
    cmd_t           cmd;
    cmd_t           cmd_nxt;
    logic           run_nxt;
    logic           load_addr;
    logic           exam_nxt;
    logic           exn_nxt;
    logic           dep_nxt;
    logic           rpt_fire;

    assign raw = {sw_run, sw_stop, sw_deposit, sw_examine_next, sw_examine};

    // Each toggle needs DEBOUNCE_CYCLES consecutive disagreeing samples to flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            db   <= '0;
            db_q <= '0;
            // NOTE: the counter array is only five registers, so every entry is reset explicitly; a true RAM would be left unreset.
            for (int i = 0; i < NSW; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            db_q <= db;
            for (int i = 0; i < NSW; i++) begin
                if (raw[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign rise = db & ~db_q;

    always_comb begin
        accept = '0;
        if      (rise[SW_STOP]) accept[SW_STOP] = 1'b1;
        else if (rise[SW_EXAM]) accept[SW_EXAM] = 1'b1;
        else if (rise[SW_EXN])  accept[SW_EXN]  = 1'b1;
        else if (rise[SW_DEP])  accept[SW_DEP]  = 1'b1;
        else if (rise[SW_RUN])  accept[SW_RUN]  = 1'b1;
    end

`ifdef FP_AUTOREPEAT_EN
    localparam logic [23:0] RPT_LAST = 24'(REPEAT_CYCLES - 1);
    logic [23:0] rpt_cnt;
    logic        rpt_hold;

    // Counting starts at the initial strobe so repeats land exactly REPEAT_CYCLES apart.
    assign rpt_hold = (state == RELEASE) && (cmd == CMD_EXN) && db[SW_EXN] && stopped;
    assign rpt_fire = rpt_hold && (rpt_cnt == RPT_LAST);

    always_ff @(posedge clk) begin
        if (reset)                   rpt_cnt <= '0;
        else if (state == PULSE)     rpt_cnt <= 24'd1;
        else if (!rpt_hold || rpt_fire) rpt_cnt <= '0;
        else                         rpt_cnt <= rpt_cnt + 24'd1;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        cmd_nxt   = cmd;
        run_nxt   = run_req;
        load_addr = 1'b0;
        exam_nxt  = 1'b0;
        exn_nxt   = 1'b0;
        dep_nxt   = 1'b0;

        if (accept[SW_STOP])     run_nxt = 1'b0;
        else if (accept[SW_RUN]) run_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (stopped) begin
                    if (accept[SW_EXAM]) begin
                        cmd_nxt   = CMD_EXAM;
                        state_nxt = LATCH;
                    end else if (accept[SW_EXN]) begin
                        cmd_nxt   = CMD_EXN;
                        state_nxt = LATCH;
                    end else if (accept[SW_DEP]) begin
                        cmd_nxt   = CMD_DEP;
                        state_nxt = LATCH;
                    end
                end
            end
            LATCH: begin
                load_addr = (cmd != CMD_EXN);
                exam_nxt  = (cmd == CMD_EXAM);
                exn_nxt   = (cmd == CMD_EXN);
                dep_nxt   = (cmd == CMD_DEP);
                state_nxt = PULSE;
            end
            PULSE: state_nxt = RELEASE;
            RELEASE: begin
                exn_nxt = rpt_fire;
                if (db == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered so they rise on the same edge the captured address does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd          <= CMD_NONE;
            run_req      <= 1'b0;
            examine      <= 1'b0;
            examine_next <= 1'b0;
            deposit      <= 1'b0;
            lo_addr      <= '0;
            hi_addr      <= '0;
            dep_data     <= '0;
            sense_s1     <= '0;
            sense_s2     <= '0;
        end else begin
            state        <= state_nxt;
            cmd          <= cmd_nxt;
            run_req      <= run_nxt;
            examine      <= exam_nxt;
            examine_next <= exn_nxt;
            deposit      <= dep_nxt;
            sense_s1     <= sense_sw;
            sense_s2     <= sense_s1;
            if (load_addr) begin
                lo_addr  <= sense_s2[7:0];
                hi_addr  <= sense_s2[15:8];
                dep_data <= sense_s2[7:0];
            end
        end
    end

endmodule
